plic_core: RTL and testbench

Single-context platform-level interrupt controller for the core0 external-interrupt input. It latches level-triggered requests from `NSRC` peripheral sources through per-source gateways and arbitrates by programmable priority. It drives `irq_ext` to the core and serves the claim/complete handshake through a word-wide register port on the D-bus.

---
 rtl/plic_core.sv | 185 ++++++++++++++++++
 tb/tb_plic_core.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/plic_core.sv
// plic_core: single-context platform-level interrupt controller feeding the
// core0 external-interrupt input.
//
// Each of the NSRC level-triggered sources runs through its own gateway
// (IDLE -> PEND -> FLIGHT -> IDLE). A priority arbiter picks the pending,
// enabled source with the highest priority above the threshold, with ties
// going to the lowest ID. The winner is registered every cycle as
// best_id/best_prio, and irq_ext is registered alongside it.
// Software claims and completes through a word-wide register port.
//
// Ports:
//   clk      system clock
//   rst      synchronous, active-high reset
//   irq_src  level requests; bit i-1 is source ID i
//   req      one-cycle access strobe
//   we       1 = write, 0 = read (qualified by req)
//   addr     byte address, bits [1:0] ignored
//   wdata    write data
//   rdata    read data, valid with ack, 0 otherwise
//   ack      access completion, one cycle after req
//   irq_ext  external interrupt to core0
//
// Register map (byte address):
//   0x000+4*i  priority[i], i = 1..NSRC
//   0x080      pending (RO)
//   0x100      enable
//   0x180      threshold
//   0x184      claim (read) / complete (write)

// Per-source gateway. Latches a level request and holds it until it is
// claimed. While the source is in flight, further requests are masked
// until software completes it.
module plic_gateway (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic claim,
    input  logic complete,
    output logic pend
);
    typedef enum logic [1:0] {IDLE, PEND, FLIGHT} gw_state_e;

    gw_state_e state, state_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (src)      state_nxt = PEND;
            PEND:    if (claim)    state_nxt = FLIGHT;
            // The source level is ignored here. A still-high level
            // re-pends on the sample after completion.
            FLIGHT:  if (complete) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    assign pend = (state == PEND);
endmodule

module plic_core #(
    parameter int NSRC   = 7,
    parameter int PRIO_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_src,
    input  logic            req,
    input  logic            we,
    input  logic [8:0]      addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            ack,
    output logic            irq_ext
);
    // IDs fit in 5 bits for the whole legal NSRC range.
    localparam int ID_W = 5;

    // Word addresses (addr[8:2]).
    localparam logic [6:0] W_PEND  = 7'h20;
    localparam logic [6:0] W_EN    = 7'h40;
    localparam logic [6:0] W_THR   = 7'h60;
    localparam logic [6:0] W_CLAIM = 7'h61;

    logic [6:0]                word;
    logic                      rd_acc, wr_acc, claim_rd, cmpl_wr;

    logic [NSRC:1][PRIO_W-1:0] prio;
    logic [NSRC:1]             en;
    logic [PRIO_W-1:0]         thr;
    logic [NSRC:1]             pend, claim_hit, cmpl_hit;

    logic [ID_W-1:0]           best_id, nxt_id;
    logic [PRIO_W-1:0]         best_prio, nxt_prio;
    logic [31:0]               rd_val;

    assign word     = addr[8:2];
    assign rd_acc   = req && !we;
    assign wr_acc   = req && we;
    assign claim_rd = rd_acc && (word == W_CLAIM);
    assign cmpl_wr  = wr_acc && (word == W_CLAIM);

    // One gateway per source. A claim targets whichever ID is registered
    // in best_id this cycle, so a claim that returns 0 touches nothing.
    // A complete only matches an exact ID, so 0 and out-of-range IDs fall
    // through. A complete for a source that is not in flight is dropped
    // inside the gateway.
    for (genvar g = 1; g <= NSRC; g++) begin : g_gw
        assign claim_hit[g] = claim_rd && (best_id == ID_W'(g));
        assign cmpl_hit[g]  = cmpl_wr && (wdata[7:0] == 8'(g));

        plic_gateway u_gw (
            .clk      (clk),
            .rst      (rst),
            .src      (irq_src[g-1]),
            .claim    (claim_hit[g]),
            .complete (cmpl_hit[g]),
            .pend     (pend[g])
        );
    end

    // Ascending scan with a strict compare. Equal priorities therefore keep
    // the lower ID. Because prio > thr >= 0, a priority-0 source never wins.
    always_comb begin
        nxt_id   = '0;
        nxt_prio = '0;
        for (int i = 1; i <= NSRC; i++) begin
            if (pend[i] && en[i] && (prio[i] > thr) && (prio[i] > nxt_prio)) begin
                nxt_id   = ID_W'(i);
                nxt_prio = prio[i];
            end
        end
    end

    always_comb begin
        rd_val = '0;
        if (word == W_PEND)
            rd_val[NSRC:1] = pend;
        else if (word == W_EN)
            rd_val[NSRC:1] = en;
        else if (word == W_THR)
            rd_val[PRIO_W-1:0] = thr;
        else if (word == W_CLAIM)
            rd_val[ID_W-1:0] = best_id;
        else begin
            for (int i = 1; i <= NSRC; i++)
                if (word == 7'(i)) rd_val[PRIO_W-1:0] = prio[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio      <= '0;
            en        <= '0;
            thr       <= '0;
            best_id   <= '0;
            best_prio <= '0;
            irq_ext   <= 1'b0;
            ack       <= 1'b0;
            rdata     <= '0;
        end else begin
            ack       <= req;
            rdata     <= rd_acc ? rd_val : '0;
            best_id   <= nxt_id;
            best_prio <= nxt_prio;
            irq_ext   <= (nxt_id != '0);
            if (wr_acc) begin
                for (int i = 1; i <= NSRC; i++)
                    if (word == 7'(i)) prio[i] <= wdata[PRIO_W-1:0];
                if (word == W_EN)  en  <= wdata[NSRC:1];
                if (word == W_THR) thr <= wdata[PRIO_W-1:0];
            end
        end
    end

    // Byte-lane bits, the upper write bits and the winner priority have no
    // consumer. The winner priority is kept registered for waveform
    // visibility.
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata[31:8], best_prio};
endmodule

// File: tb/tb_plic_core.sv
module tb_plic_core;
    localparam int NSRC   = 7;
    localparam int PRIO_W = 3;

    logic            clk = 1'b0;
    logic            rst, req, we, ack, irq_ext;
    logic [NSRC-1:0] irq_src;
    logic [8:0]      addr;
    logic [31:0]     wdata, rdata;

    int total = 0;
    int bad   = 0;

    plic_core #(.NSRC(NSRC), .PRIO_W(PRIO_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .irq_src (irq_src),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .ack     (ack),
        .irq_ext (irq_ext)
    );

    always #5 clk = ~clk;

    // Reference model: per-source pending/in-flight flags plus the register
    // file. It is advanced once per clock edge from the spec rules.
    bit [NSRC:1] m_pend = '0, m_flt = '0;
    int          m_prio [0:NSRC];
    bit [31:0]   m_en = '0;
    int          m_thr = 0, m_best = 0;
    bit          m_irq = 0, m_ack = 0;
    bit [31:0]   m_rdata = '0;

    function automatic int arb();
        int best = 0, bp = 0;
        for (int i = 1; i <= NSRC; i++)
            if (m_pend[i] && m_en[i] && m_prio[i] > m_thr && m_prio[i] > bp) begin
                best = i;
                bp = m_prio[i];
            end
        return best;
    endfunction

    function automatic bit [31:0] rd_model(int w);
        bit [31:0] r = '0;
        if (w >= 1 && w <= NSRC) r = 32'(m_prio[w]);
        else if (w == 32'h20)    r[NSRC:1] = m_pend;
        else if (w == 32'h40)    r = m_en;
        else if (w == 32'h60)    r = 32'(m_thr);
        else if (w == 32'h61)    r = 32'(m_best);
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: compute the model's next state from the current
    // inputs, let the edge pass, then compare outputs 1 time unit later.
    task automatic cyc();
        bit [NSRC:1] np, nf;
        int          npr [0:NSRC];
        int          nthr, nbest, w, cid;
        bit [31:0]   nen, nrd;
        bit          nack;
        np = m_pend; nf = m_flt; npr = m_prio; nthr = m_thr; nen = m_en;
        nbest = arb(); nack = 0; nrd = '0;
        w = int'(addr[8:2]);
        cid = int'(wdata[7:0]);
        if (req) begin
            nack = 1;
            if (!we) begin
                nrd = rd_model(w);
                if (w == 32'h61 && m_best != 0) begin
                    np[m_best] = 0;
                    nf[m_best] = 1;
                end
            end else begin
                if (w >= 1 && w <= NSRC) npr[w] = int'(wdata) & ((1 << PRIO_W) - 1);
                if (w == 32'h40) nen = wdata & (((32'd1 << (NSRC + 1)) - 1) & ~32'd1);
                if (w == 32'h60) nthr = int'(wdata) & ((1 << PRIO_W) - 1);
                if (w == 32'h61 && cid >= 1 && cid <= NSRC && m_flt[cid]) nf[cid] = 0;
            end
        end
        for (int i = 1; i <= NSRC; i++)
            if (!m_pend[i] && !m_flt[i] && irq_src[i-1]) np[i] = 1;
        if (rst) begin
            np = '0; nf = '0; nthr = 0; nen = '0; nbest = 0; nack = 0; nrd = '0;
            for (int i = 0; i <= NSRC; i++) npr[i] = 0;
        end
        @(posedge clk);
        m_pend = np; m_flt = nf; m_prio = npr; m_thr = nthr; m_en = nen;
        m_best = nbest; m_irq = (nbest != 0); m_ack = nack; m_rdata = nrd;
        #1;
        chk("irq_ext", {31'd0, irq_ext}, {31'd0, m_irq});
        chk("ack", {31'd0, ack}, {31'd0, m_ack});
        chk("rdata", rdata, m_rdata);
    endtask

    task automatic wr(int a, int d);
        req = 1; we = 1; addr = 9'(a); wdata = 32'(d);
        cyc();
        req = 0; we = 0;
        cyc();
    endtask

    task automatic rd(int a, output logic [31:0] d);
        req = 1; we = 0; addr = 9'(a);
        cyc();
        d = rdata;
        req = 0;
        cyc();
    endtask

    task automatic do_reset();
        rst = 1; irq_src = '0;
        cyc(); cyc();
        rst = 0;
        cyc();
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    initial begin
        logic [31:0] d;
        for (int i = 0; i <= NSRC; i++) m_prio[i] = 0;
        rst = 1; req = 0; we = 0; addr = '0; wdata = '0; irq_src = '0;

        // Reset and defaults
        do_reset();
        rd(12'h080, d); chk("rst_pend", d, 0);
        rd(12'h100, d); chk("rst_en", d, 0);
        rd(12'h180, d); chk("rst_thr", d, 0);
        rd(12'h184, d); chk("rst_claim", d, 0);
        irq_src[2] = 1'b1;
        idle(4);
        chk("prio0_irq", {31'd0, irq_ext}, 0);
        rd(12'h184, d); chk("prio0_claim", d, 0);

        // Basic flow
        do_reset();
        wr(12'h00C, 2); wr(12'h100, 32'h08); wr(12'h180, 0);
        irq_src[2] = 1'b1;
        cyc(); chk("basic_irq_t", {31'd0, irq_ext}, 0);
        cyc(); chk("basic_irq_t1", {31'd0, irq_ext}, 1);
        rd(12'h184, d); chk("basic_claim", d, 3);
        chk("basic_irq_drop", {31'd0, irq_ext}, 0);
        rd(12'h080, d); chk("basic_pend", d, 0);
        wr(12'h184, 3);
        cyc(); chk("basic_repend_irq", {31'd0, irq_ext}, 1);
        rd(12'h080, d); chk("basic_repend", d, 32'h08);

        // Arbitration
        do_reset();
        wr(12'h008, 5); wr(12'h014, 5); wr(12'h018, 7); wr(12'h100, 32'h64);
        irq_src = 7'b0110010;
        idle(3);
        irq_src = '0;
        rd(12'h184, d); chk("arb_1st", d, 6);
        rd(12'h184, d); chk("arb_2nd", d, 2);
        rd(12'h184, d); chk("arb_3rd", d, 5);
        rd(12'h184, d); chk("arb_none", d, 0);

        // Threshold
        do_reset();
        wr(12'h004, 4); wr(12'h100, 32'h02); wr(12'h180, 4);
        irq_src[0] = 1'b1;
        idle(3);
        chk("thr_eq_irq", {31'd0, irq_ext}, 0);
        req = 1; we = 1; addr = 9'h180; wdata = 32'd3;
        cyc(); chk("thr_edge_irq", {31'd0, irq_ext}, 0);
        req = 0; we = 0;
        cyc(); chk("thr_after_irq", {31'd0, irq_ext}, 1);

        // Bad complete
        do_reset();
        wr(12'h010, 1); wr(12'h100, 32'h10);
        irq_src[3] = 1'b1;
        idle(3);
        rd(12'h184, d); chk("bad_claim", d, 4);
        wr(12'h184, 0); wr(12'h184, 9); wr(12'h184, 2);
        idle(3);
        rd(12'h080, d); chk("bad_pend", d, 0);
        chk("bad_irq", {31'd0, irq_ext}, 0);
        wr(12'h184, 4);
        idle(2);
        rd(12'h080, d); chk("good_pend", d, 32'h10);
        chk("good_irq", {31'd0, irq_ext}, 1);

        // Mid-operation reset during a claim request
        req = 1; we = 0; addr = 9'h184; rst = 1; irq_src = '0;
        cyc(); chk("midrst_ack", {31'd0, ack}, 0);
        req = 0; rst = 0;
        cyc(); chk("midrst_ack2", {31'd0, ack}, 0);
        chk("midrst_irq", {31'd0, irq_ext}, 0);
        rd(12'h010, d); chk("midrst_prio", d, 0);
        rd(12'h100, d); chk("midrst_en", d, 0);
        rd(12'h180, d); chk("midrst_thr", d, 0);
        rd(12'h080, d); chk("midrst_pend", d, 0);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            irq_src = NSRC'($urandom);
            case ($urandom_range(0, 7))
                0:       wr(4 * int'($urandom_range(0, NSRC + 1)), int'($urandom));
                1:       wr(12'h100, int'($urandom));
                2:       wr(12'h180, int'($urandom_range(0, 7)));
                3, 4:    rd(12'h184, d);
                5:       wr(12'h184, int'($urandom_range(0, NSRC + 2)));
                6:       rd(int'($urandom_range(0, 511)), d);
                default: cyc();
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
